// File: rtl/pipe_stage_buf.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_stage_buf
//  Description : Generic inter-stage pipeline buffer. It is a valid/ready FIFO
//                of DEPTH entries, each holding a packed DATA_W-bit payload,
//                with a synchronous flush for branch/exception kill.
//                With DEPTH=2 it sustains one transfer per cycle. s_ready,
//                m_valid and m_data come only from registered state, so no
//                combinational path runs from any input to them.
//                Optional performance counters are built when the macro
//                PIPE_BUF_PERF_EN is defined.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters:
//    DATA_W  payload width in bits (>=1)
//    DEPTH   number of entries (>=1, any value, not only powers of 2)
//    CNT_W   width of the performance counters (PIPE_BUF_PERF_EN only)
//  Ports:
//    clk         clock
//    rst         synchronous active-high reset; clears state, storage, counters
//    flush       synchronous discard of all held entries
//    s_valid     upstream payload valid
//    s_ready     buffer can accept (not full); independent of m_ready
//    s_data      upstream payload
//    m_valid     head entry valid (not empty)
//    m_ready     downstream accepts head
//    m_data      head entry payload, driven from storage
//    count       current occupancy, 0..DEPTH
//    perf_xfer   saturating count of output transfers (PIPE_BUF_PERF_EN)
//    perf_stall  saturating count of cycles with m_valid & !m_ready
//                (PIPE_BUF_PERF_EN)
// ============================================================================
module pipe_stage_buf #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2,
    parameter int CNT_W  = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         s_valid,
    output logic                         s_ready,
    input  logic [DATA_W-1:0]            s_data,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic [DATA_W-1:0]            m_data,
    output logic [$clog2(DEPTH+1)-1:0]   count
`ifdef PIPE_BUF_PERF_EN
    ,
    output logic [CNT_W-1:0]             perf_xfer,
    output logic [CNT_W-1:0]             perf_stall
`endif
);

    localparam int c_cnt_w = $clog2(DEPTH + 1);
    // A single-entry buffer still needs a 1-bit pointer; it simply never moves.
    localparam int c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [c_cnt_w-1:0] c_full_cnt = c_cnt_w'(DEPTH);
    localparam logic [c_ptr_w-1:0] c_last_ptr = c_ptr_w'(DEPTH - 1);

    logic [DATA_W-1:0]  r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_cnt_w-1:0] r_cnt;

    logic w_s_ready;
    logic w_m_valid;
    logic w_push;
    logic w_pop;

    // Pointers wrap explicitly at DEPTH-1 so that non-power-of-2 depths work.
    function automatic logic [c_ptr_w-1:0] f_ptr_inc(input logic [c_ptr_w-1:0] ptr);
        if (ptr == c_last_ptr) begin
            return '0;
        end
        return ptr + c_ptr_w'(1);
    endfunction

    assign w_s_ready = (r_cnt != c_full_cnt);
    assign w_m_valid = (r_cnt != '0);

    // When full, s_ready is low, so a same-cycle pop cannot make room for a
    // push. This keeps s_ready free of any dependence on m_ready.
    assign w_push = s_valid & w_s_ready;
    assign w_pop  = w_m_valid & m_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (flush) begin
            // Storage is left untouched; once the count is zero it is never
            // presented as valid.
            r_cnt    <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= s_data;
                r_wr_ptr        <= f_ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= f_ptr_inc(r_rd_ptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + c_cnt_w'(1);
                2'b01:   r_cnt <= r_cnt - c_cnt_w'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    assign s_ready = w_s_ready;
    assign m_valid = w_m_valid;
    assign m_data  = r_mem[r_rd_ptr];
    assign count   = r_cnt;

`ifdef PIPE_BUF_PERF_EN
    logic [CNT_W-1:0] r_perf_xfer;
    logic [CNT_W-1:0] r_perf_stall;

    // Both counters saturate at all-ones. Only rst clears them; a flush
    // leaves them running so kill events do not hide earlier activity.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_xfer  <= '0;
            r_perf_stall <= '0;
        end else begin
            if (w_pop && (r_perf_xfer != '1)) begin
                r_perf_xfer <= r_perf_xfer + CNT_W'(1);
            end
            if (w_m_valid && !m_ready && (r_perf_stall != '1)) begin
                r_perf_stall <= r_perf_stall + CNT_W'(1);
            end
        end
    end

    assign perf_xfer  = r_perf_xfer;
    assign perf_stall = r_perf_stall;
`else
    // Counter width is meaningless without the counters.
    localparam int c_unused_cnt_w = CNT_W;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_buf.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_stage_buf
//  Description : Self-checking bench for pipe_stage_buf. Three instances
//                (DEPTH = 1, 2, 3) share one input stream; each is compared
//                every cycle against a queue-based reference model. Perf
//                counters are checked when PIPE_BUF_PERF_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_buf;

    localparam int N_INST = 3;
    localparam int SAT    = 15;    // all-ones for CNT_W = 4

    logic        clk     = 1'b0;
    logic        rst     = 1'b1;
    logic        flush   = 1'b0;
    logic        s_valid = 1'b0;
    logic [31:0] s_data  = '0;
    logic        m_ready = 1'b0;

    logic        mv     [N_INST];
    logic        sr     [N_INST];
    logic [31:0] md     [N_INST];
    logic [1:0]  cnt_o  [N_INST];
    logic [3:0]  px     [N_INST];
    logic [3:0]  ps     [N_INST];

    always #5 clk = ~clk;

    for (genvar k = 0; k < N_INST; k++) begin : g_dut
        localparam int D = k + 1;
        logic [$clog2(D+1)-1:0] c;
        logic                   mv_l;
        logic                   sr_l;
        logic [31:0]            md_l;
`ifdef PIPE_BUF_PERF_EN
        logic [3:0]             px_l;
        logic [3:0]             ps_l;
`endif
        pipe_stage_buf #(
            .DATA_W (32),
            .DEPTH  (D),
            .CNT_W  (4)
        ) u_dut (
            .clk        (clk),
            .rst        (rst),
            .flush      (flush),
            .s_valid    (s_valid),
            .s_ready    (sr_l),
            .s_data     (s_data),
            .m_valid    (mv_l),
            .m_ready    (m_ready),
            .m_data     (md_l),
            .count      (c)
`ifdef PIPE_BUF_PERF_EN
            ,
            .perf_xfer  (px_l),
            .perf_stall (ps_l)
`endif
        );
        assign mv[k]    = mv_l;
        assign sr[k]    = sr_l;
        assign md[k]    = md_l;
        assign cnt_o[k] = 2'(c);
`ifdef PIPE_BUF_PERF_EN
        assign px[k]    = px_l;
        assign ps[k]    = ps_l;
`else
        assign px[k]    = '0;
        assign ps[k]    = '0;
`endif
    end

    // Reference model: one bounded queue per instance plus perf totals.
    logic [31:0] mq [N_INST][$];
    int          xf [N_INST];
    int          st [N_INST];
    bit          pristine [N_INST];   // no push since reset: storage all zero

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input int k, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s[depth%0d] observed=%h expected=%h", tag, k + 1, obs, exp);
        end
    endtask

    // Apply one clock edge: advance the model with the inputs seen at the
    // edge, then compare every instance a little after the edge.
    task automatic step();
        @(posedge clk);
        for (int k = 0; k < N_INST; k++) begin
            int  cap;
            bit  vld;
            bit  rdy;
            cap = k + 1;
            if (rst) begin
                mq[k].delete();
                xf[k] = 0;
                st[k] = 0;
                pristine[k] = 1'b1;
            end else begin
                vld = (mq[k].size() > 0);
                rdy = (mq[k].size() < cap);
                if (vld && m_ready && xf[k] < SAT)  xf[k]++;
                if (vld && !m_ready && st[k] < SAT) st[k]++;
                if (flush) begin
                    mq[k].delete();
                end else begin
                    if (vld && m_ready) void'(mq[k].pop_front());
                    if (rdy && s_valid) begin
                        mq[k].push_back(s_data);
                        pristine[k] = 1'b0;
                    end
                end
            end
        end
        #1;
        for (int k = 0; k < N_INST; k++) begin
            chk("m_valid", k, 32'(mv[k]), 32'(mq[k].size() != 0));
            chk("s_ready", k, 32'(sr[k]), 32'(mq[k].size() != k + 1));
            chk("count",   k, 32'(cnt_o[k]), 32'(mq[k].size()));
            if (mq[k].size() != 0)  chk("m_data", k, md[k], mq[k][0]);
            else if (pristine[k])   chk("m_data_rst", k, md[k], 32'h0);
`ifdef PIPE_BUF_PERF_EN
            chk("perf_xfer",  k, 32'(px[k]), 32'(xf[k]));
            chk("perf_stall", k, 32'(ps[k]), 32'(st[k]));
`endif
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] d, input logic rdy,
                         input logic fl);
        s_valid = v;
        s_data  = d;
        m_ready = rdy;
        flush   = fl;
    endtask

    initial begin
        // Reset, then idle.
        rst = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        step();
        step();
        rst = 1'b0;
        step();
        step();

        // Streaming with m_ready held high.
        drive(1'b1, 32'h11, 1'b1, 1'b0); step();
        drive(1'b1, 32'h22, 1'b1, 1'b0); step();
        drive(1'b1, 32'h33, 1'b1, 1'b0); step();
        drive(1'b0, 32'h0,  1'b1, 1'b0); step();
        step();

        // Fill to full with downstream stalled, hold C, release one pop.
        drive(1'b1, 32'hA, 1'b0, 1'b0); step();
        drive(1'b1, 32'hB, 1'b0, 1'b0); step();
        drive(1'b1, 32'hC, 1'b0, 1'b0); step();
        step();
        drive(1'b1, 32'hC, 1'b1, 1'b0); step();
        drive(1'b1, 32'hC, 1'b0, 1'b0); step();
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step();

        // Interleaved traffic across the pointer wrap.
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 32'h100 + 32'(i), (i % 3) != 0, 1'b0);
            step();
        end
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step();

        // Flush with a coincident push while holding two entries.
        drive(1'b1, 32'h51, 1'b0, 1'b0); step();
        drive(1'b1, 32'h52, 1'b0, 1'b0); step();
        drive(1'b1, 32'h55, 1'b0, 1'b1); step();
        drive(1'b0, 32'h0,  1'b0, 1'b0); step();
        drive(1'b0, 32'h0,  1'b1, 1'b0); step();

        // Perf saturation: fresh reset, one entry held for 20 stalled cycles,
        // then a single pop.
        rst = 1'b1; step();
        rst = 1'b0;
        drive(1'b1, 32'h77, 1'b0, 1'b0); step();
        drive(1'b0, 32'h0,  1'b0, 1'b0);
        for (int i = 0; i < 20; i++) step();
        drive(1'b0, 32'h0, 1'b1, 1'b0); step();
        drive(1'b0, 32'h0, 1'b0, 1'b0); step();

        // Randomised traffic with occasional flush and reset.
        for (int i = 0; i < 600; i++) begin
            logic fl;
            fl  = ($urandom_range(0, 19) == 0);
            rst = ($urandom_range(0, 99) == 0);
            // Flush cycles keep m_ready low so a killed pop is never counted.
            drive($urandom_range(0, 2) != 0, $urandom(),
                  fl ? 1'b0 : ($urandom_range(0, 3) != 0), fl);
            step();
        end
        rst = 1'b0;
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipe_stage_buf.md
Name: pipe_stage_buf

Overview:
Parametrised inter-stage pipeline buffer. It replaces the fixed-field, two-state stage registers between pipeline stages (E→M, M→W, etc.) with a generic valid/ready FIFO of DEPTH entries carrying a packed DATA_W-bit payload. DEPTH=2 sustains one transfer per cycle with no combinational ready path. It adds a synchronous flush for branch/exception kill.

Parameters:
DATA_W, 32, payload width in bits (≥1); stages concatenate their fields into it.
DEPTH, 2, number of entries (≥1, need not be a power of 2).
CNT_W, 32, width of perf counters (used only with PIPE_BUF_PERF_EN).

Ports:
clk  in  1  clock.
rst  in  1  reset, synchronous, active-high.
flush  in  1  discard all held entries; synchronous.
s_valid  in  1  upstream has payload.
s_ready  out  1  buffer can accept; registered-state-derived, independent of m_ready.
s_data  in  DATA_W  upstream payload.
m_valid  out  1  head entry valid.
m_ready  in  1  downstream accepts head.
m_data  out  DATA_W  head entry payload, driven from storage.
count  out  $clog2(DEPTH+1)  current occupancy.
perf_xfer  out  CNT_W  output transfers (PIPE_BUF_PERF_EN only).
perf_stall  out  CNT_W  cycles with m_valid & !m_ready (PIPE_BUF_PERF_EN only).

Behaviour:
- State: storage array[DEPTH], rd_ptr, wr_ptr (0..DEPTH-1), occupancy cnt (0..DEPTH).
- Reset: cnt=0, both pointers=0, all storage=0. Outputs after reset: m_valid=0, s_ready=1, m_data=0, count=0, perf counters=0.
- push = s_valid & s_ready; pop = m_valid & m_ready; both evaluated on the same edge.
- s_ready = (cnt != DEPTH). m_valid = (cnt != 0). m_data = storage[rd_ptr]. No combinational path exists from any input to s_ready, m_valid or m_data.
- Latency: a payload pushed at edge N is presented on m_data/m_valid after edge N, so it is poppable in cycle N+1. Storage is written only on push; entries stay stable while held.
- Ordering: strict FIFO. Payload is never modified and never dropped except by flush.
- Pointer update: push writes storage[wr_ptr] and advances wr_ptr. Pop advances rd_ptr. Pointers wrap DEPTH-1 → 0 explicitly; there is no reliance on power-of-2 overflow.
- Occupancy: push only → cnt+1; pop only → cnt-1; push and pop together → unchanged.
- Full: s_ready=0, so push is impossible even if pop occurs the same cycle. Pop that cycle frees a slot and s_ready=1 next cycle.
- Empty: m_valid=0; m_ready is ignored.
- DEPTH=1: throughput is one transfer per 2 cycles, equivalent to the old IDLE/WAIT_READY behaviour. DEPTH≥2 sustains 1/cycle.
- Flush: at the edge, cnt=0 and rd_ptr=wr_ptr=0; any coincident push/pop is discarded. Storage contents are don't-care except after rst.
- Flush result: m_valid=0 and s_ready=1 in the following cycle.
- Precedence: rst > flush > push/pop.
- Reset mid-operation: all in-flight entries are lost and the reset values above apply the next cycle.
- Upstream protocol: once s_valid is asserted it holds s_valid and s_data until s_ready.
- Downstream guarantee: m_valid/m_data are held until pop or flush.

Optional Feature:
Macro PIPE_BUF_PERF_EN.
- Defined: perf_xfer increments on each pop. perf_stall increments on each cycle with m_valid & !m_ready.
- Counter rules: both saturate at all-ones, both clear on rst, and flush does not clear them.
- Undefined: perf ports and their logic are absent; all other behaviour is identical.

Test Plan:
1. Reset then idle, DEPTH=2 → m_valid=0, s_ready=1, count=0, m_data=0.
2. DEPTH=2, m_ready=1, push 0x11,0x22,0x33 on consecutive cycles → m_data 0x11,0x22,0x33 on cycles N+1..N+3; s_ready stays 1 (full throughput).
3. DEPTH=2, m_ready=0, push 0xA,0xB → count=2, s_ready=0. Attempted 0xC is not accepted. Raise m_ready for one cycle → 0xA popped, 0xC accepted the next cycle, order A,B,C preserved.
4. DEPTH=3, run 7 pushes/pops interleaved → data is in order across pointer wrap 2→0; count never exceeds 3.
5. count=2 with flush=1 and s_valid=1 in the same cycle → next cycle count=0, m_valid=0, s_ready=1; the flushed push never appears.
6. PIPE_BUF_PERF_EN, CNT_W=4, m_ready=0 for 20 cycles with one entry held → perf_stall=15 (saturated); after 1 pop perf_xfer=1.
